// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding plus the address, word and stream widths
// used by imem_loader, word_assembler and imem_loader_if.
package loader_pkg;

  localparam int ADD_INST_SIZE  = 8;   // instruction-memory byte-address width
  localparam int SIZE_DATA      = 32;  // instruction word width
  localparam int BYTE_W         = 8;   // stream byte width
  localparam int MAX_WORDS      = 64;  // 2^ADD_INST_SIZE / 4
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 7;   // wide enough to hold MAX_WORDS itself

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   rx_valid/rx_data/rx_ready : valid/ready byte stream into the loader
//   mem_we/mem_addr/mem_wdata : single-word write port of the instruction memory
// master : the loader side (consumes the stream, drives the memory write)
// slave  : the environment side (stream source and memory)
interface imem_loader_if;
  import loader_pkg::*;

  logic                     rx_valid;
  logic [BYTE_W-1:0]        rx_data;
  logic                     rx_ready;
  logic                     mem_we;
  logic [ADD_INST_SIZE-1:0] mem_addr;
  logic [SIZE_DATA-1:0]     mem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: big-endian word builder for the loader.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : drop any partial word and restart at byte 0
//   shift_en   : shift byte_in into the low byte, oldest byte ends up as MSB
//   byte_in    : incoming stream byte
//   word       : current contents of the shift register
//   word_full  : the byte shifted in this cycle completes the word
module word_assembler
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [BYTE_W-1:0]    byte_in,
  output logic [SIZE_DATA-1:0] word,
  output logic                 word_full
);

  logic [1:0] byte_idx;

  // The 2-bit index wraps to 0 after the 4th byte, so the next word
  // starts cleanly without the FSM having to clear it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (shift_en) begin
      word     <= {word[SIZE_DATA-BYTE_W-1:0], byte_in};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  assign word_full = (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a program image into instruction memory from a byte stream
// and keeps the MIPS32 core in reset until the image is complete.
// Image format: one count byte N (1..MAX_WORDS), then N big-endian 32-bit words.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   start        : one-cycle request to begin a load (ignored while busy)
//   bus          : imem_loader_if.master, byte stream in and memory write out
//   core_reset   : held high except when a load has completed successfully
//   busy/done/error : load in progress / image loaded / load aborted
//   words_loaded : words written so far in the current load
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte over the payload (count byte excluded) before the core is released.
module imem_loader
  import loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  imem_loader_if.master    bus,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  loader_state_t    state, state_next;
  logic [CNT_W-1:0] word_count;
  logic             accept;
  logic             shift_en;
  logic             clear;
  logic             latch_count;
  logic             inc_words;
  logic             word_full;

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xsum;
`endif

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .shift_en  (shift_en),
    .byte_in   (bus.rx_data),
    .word      (bus.mem_wdata),
    .word_full (word_full)
  );

  assign accept         = bus.rx_valid & bus.rx_ready;
  assign bus.rx_ready   = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign bus.mem_we     = (state == WRITE);
  assign bus.mem_addr   = ADD_INST_SIZE'({words_loaded, 2'b00});
  assign busy           = (state == COUNT) || (state == DATA) ||
                          (state == WRITE) || (state == CHECK);
  assign done           = (state == DONE);
  assign error          = (state == ERROR);
  assign core_reset     = (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; also produces the one-cycle controls for the
  // word assembler and the word counters.
  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    clear       = 1'b0;
    latch_count = 1'b0;
    inc_words   = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = COUNT;
          clear      = 1'b1;
        end
      end
      COUNT: begin
        if (accept) begin
          if (bus.rx_data == '0 || bus.rx_data > BYTE_W'(MAX_WORDS)) begin
            state_next = ERROR;
          end else begin
            latch_count = 1'b1;
            state_next  = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          shift_en = 1'b1;
          if (word_full) state_next = WRITE;
        end
      end
      WRITE: begin
        inc_words = 1'b1;
        if (words_loaded + CNT_W'(1) == word_count) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (bus.rx_data == xsum) state_next = DONE;
          else                     state_next = ERROR;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Image length and progress counters; the checksum accumulates only
  // payload bytes, which are exactly the bytes shifted into the assembler.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count   <= '0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      xsum         <= '0;
`endif
    end else begin
      if (clear) begin
        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
        xsum         <= '0;
`endif
      end
      if (latch_count) word_count   <= bus.rx_data[CNT_W-1:0];
      if (inc_words)   words_loaded <= words_loaded + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
      if (shift_en)    xsum         <= xsum ^ bus.rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Expected values are hand-computed from the image contents.
module tb_imem_loader;
  import loader_pkg::*;

  logic             clk;
  logic             reset;
  logic             start;
  logic             core_reset;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  imem_loader_if bus ();

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  img[$];
  logic [7:0]  wrAddr[$];
  logic [31:0] wrData[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wrAddr.push_back(bus.mem_addr);
      wrData.push_back(bus.mem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Offer one byte from a negedge; returns at the negedge after it was taken.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    guard = 0;
    while (bus.rx_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic waitEnd(input string tag);
    int guard;
    guard = 0;
    while (done !== 1'b1 && error !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Pulse start, stream the current image, wait for done or error.
  task automatic applyStimulus(input string tag, input bit gaps);
    wrAddr.delete();
    wrData.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (img[i]) sendByte(img[i], gaps);
    bus.rx_valid = 1'b0;
    waitEnd(tag);
  endtask

  task automatic buildTwoWord(input logic [7:0] chk);
    img.delete();
    img = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h2A, 8'h40, 8'h20};
`ifdef LOADER_CHECKSUM_EN
    img.push_back(chk);
`else
    if (chk == 8'h00) img.delete();
`endif
  endtask

  task automatic checkTwoWord(input string tag);
    checkOutput({tag, "_nwrites"}, wrAddr.size(), 2);
    if (wrAddr.size() == 2) begin
      checkOutput({tag, "_addr0"}, wrAddr[0], 8'h00);
      checkOutput({tag, "_data0"}, wrData[0], 32'h20080005);
      checkOutput({tag, "_addr1"}, wrAddr[1], 8'h04);
      checkOutput({tag, "_data1"}, wrData[1], 32'h012A4020);
    end
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_core_reset"}, core_reset, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_words"}, words_loaded, 7'd2);
    checkOutput({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_core_reset"}, core_reset, 1'b1);
    checkOutput({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
    checkOutput({tag, "_mem_we"}, bus.mem_we, 1'b0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 8'h00);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_error"}, error, 1'b0);
    checkOutput({tag, "_words"}, words_loaded, 7'd0);
  endtask

  task automatic checkBadCount(input string tag, input logic [7:0] n);
    img.delete();
    img.push_back(n);
    applyStimulus(tag, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_error"}, error, 1'b1);
    checkOutput({tag, "_core_reset"}, core_reset, 1'b1);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_nwrites"}, wrAddr.size(), 0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;

    // Plain two-word load, valid held high across the WRITE cycles
    buildTwoWord(8'h66);
    applyStimulus("load2", 1'b0);
    checkTwoWord("load2");

    // Illegal counts
    checkBadCount("count00", 8'h00);
    checkBadCount("count41", 8'h41);

    // Same load with random gaps in rx_valid
    buildTwoWord(8'h66);
    applyStimulus("stall", 1'b1);
    checkTwoWord("stall");

    // Largest image: last word lands at 0xFC
    img.delete();
    img.push_back(8'h40);
    for (int i = 0; i < 64; i++) repeat (4) img.push_back(8'(i));
`ifdef LOADER_CHECKSUM_EN
    img.push_back(8'h00);
`endif
    applyStimulus("load64", 1'b0);
    checkOutput("load64_nwrites", wrAddr.size(), 64);
    if (wrAddr.size() == 64) begin
      checkOutput("load64_addr_last", wrAddr[63], 8'hFC);
      checkOutput("load64_data_last", wrData[63], 32'h3F3F3F3F);
      checkOutput("load64_addr_mid", wrAddr[17], 8'h44);
      checkOutput("load64_data_mid", wrData[17], 32'h11111111);
    end
    checkOutput("load64_done", done, 1'b1);
    checkOutput("load64_words", words_loaded, 7'd64);

    // Reset after two data bytes
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sendByte(8'h02, 1'b0);
    sendByte(8'h20, 1'b0);
    sendByte(8'h08, 1'b0);
    bus.rx_valid = 1'b0;
    checkOutput("midload_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState("midload");
    buildTwoWord(8'h66);
    applyStimulus("reload", 1'b0);
    checkTwoWord("reload");

    // start and reset in the same cycle: reset wins
    @(negedge clk);
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    checkResetState("start_reset");
    repeat (2) @(negedge clk);
    checkOutput("start_reset_idle_busy", busy, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    buildTwoWord(8'h67);
    applyStimulus("badsum", 1'b0);
    checkOutput("badsum_error", error, 1'b1);
    checkOutput("badsum_core_reset", core_reset, 1'b1);
    checkOutput("badsum_done", done, 1'b0);
    checkOutput("badsum_nwrites", wrAddr.size(), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
